// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core run/halt/step sequencer:
// state encodings and the stall counter saturation value.
package core_ctrl_pkg;

   typedef enum logic [1:0] {
      HALT  = 2'd0,
      RUN   = 2'd1,
      STEP  = 2'd2,
      STALL = 2'd3
   } run_state_t;

   localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/core_tick_gen.sv
// Free-running modulo-DIV_RATIO divider. The registered tick output is
// high during the cycle in which the count equals DIV_RATIO-1.
module core_tick_gen #(
   parameter int DIV_RATIO = 9
) (
   input  logic clk,
   input  logic n_rst,
   output logic tick
);

   localparam logic [7:0] LAST     = 8'(DIV_RATIO - 1);
   localparam logic [7:0] PRE_LAST = 8'(DIV_RATIO - 2);

   logic [7:0] count_reg;
   logic       tick_reg;

   // Count wraps at DIV_RATIO-1; tick is registered one count early so it
   // lines up with the terminal count.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count_reg <= 8'd0;
         tick_reg  <= 1'b0;
      end else begin
         count_reg <= (count_reg == LAST) ? 8'd0 : count_reg + 8'd1;
         tick_reg  <= (count_reg == PRE_LAST);
      end
   end

   assign tick = tick_reg;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/single-step sequencer for the core. Issues one-cycle core
// enables on divider ticks, withholds them when the writeback buffer is
// near full, and produces the buffer push strobe one cycle after core_en.
// Optional feature macro: CORE_RUN_CTRL_STALL_CNT_EN (stall tick counter).
module core_run_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int DIV_RATIO   = 9,
   parameter int OCC_W       = 6,
   parameter int FULL_THRESH = 30
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic [OCC_W-1:0] buffer_occ,
   input  logic             wb_valid,
   output logic             core_en,
   output logic             buf_push,
   output logic [1:0]       state_out,
   output logic [15:0]      stall_cnt
);

   localparam logic [OCC_W-1:0] THRESH = OCC_W'(FULL_THRESH);

   logic       tick;
   logic       occ_full;
   run_state_t state_reg;
   run_state_t state_next;
   run_state_t req_state;
   logic       core_en_reg;
   logic       core_en_next;
   logic       buf_push_reg;
   logic       stall_inc;

   core_tick_gen #(
      .DIV_RATIO (DIV_RATIO)
   ) u_tick_gen (
      .clk   (clk),
      .n_rst (n_rst),
      .tick  (tick)
   );

   assign occ_full = (buffer_occ >= THRESH);

   // Resolve requests first, then apply the tick action to the resolved state.
   always_comb begin
      req_state    = state_reg;
      state_next   = state_reg;
      core_en_next = 1'b0;
      stall_inc    = 1'b0;

      case (state_reg)
         HALT: begin
            if (halt_req)      req_state = HALT;
            else if (step_req) req_state = STEP;
            else if (run_req)  req_state = RUN;
         end
         RUN, STEP, STALL: begin
            if (halt_req) req_state = HALT;
         end
         default: req_state = HALT;
      endcase

      state_next = req_state;
      if (tick) begin
         case (req_state)
            RUN: begin
               if (occ_full) begin
                  state_next = STALL;
                  stall_inc  = 1'b1;
               end else begin
                  core_en_next = 1'b1;
               end
            end
            STEP: begin
               if (occ_full) begin
                  stall_inc = 1'b1;
               end else begin
                  core_en_next = 1'b1;
                  state_next   = HALT;
               end
            end
            STALL: begin
               if (occ_full) begin
                  stall_inc = 1'b1;
               end else begin
                  core_en_next = 1'b1;
                  state_next   = RUN;
               end
            end
            default: ;
         endcase
      end
   end

   // State, core enable and the push pipeline stage; reset drops any pending push.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_reg    <= HALT;
         core_en_reg  <= 1'b0;
         buf_push_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         core_en_reg  <= core_en_next;
         buf_push_reg <= core_en_reg & wb_valid;
      end
   end

`ifdef CORE_RUN_CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt_reg;

   // Saturating count of ticks withheld because of buffer backpressure.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         stall_cnt_reg <= 16'd0;
      end else if (stall_inc && (stall_cnt_reg != STALL_CNT_MAX)) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`else
   logic stall_inc_unused;
   assign stall_inc_unused = stall_inc;
   assign stall_cnt        = 16'h0000;
`endif

   assign core_en   = core_en_reg;
   assign buf_push  = buf_push_reg;
   assign state_out = state_reg;

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run/halt/single-step sequencer for the RV32I core on the board top level. It divides the board clock into core step ticks and issues one-cycle core enables on those ticks. It also applies backpressure from the writeback Data_Buffer occupancy, stalling the core when the buffer nears full, and generates the buffer push strobe. All outputs are registered and the block is clocked by the single board clock.

## Interface
- DIV_RATIO, 9: board-clock cycles per step tick; legal range 2..255.
- OCC_W, 6: width of buffer occupancy input.
- FULL_THRESH, 30: occupancy at or above which core steps are withheld.
- clk  in  1  board clock; single clock domain.
- n_rst  in  1  reset, synchronous and active-low.
- run_req  in  1  enter free-running mode (pulse or level).
- halt_req  in  1  stop issuing core steps.
- step_req  in  1  issue exactly one core step, then halt.
- buffer_occ  in  OCC_W  current Data_Buffer occupancy.
- wb_valid  in  1  core produced a writeback during the core_en cycle.
- core_en  out  1  one-cycle core advance enable.
- buf_push  out  1  one-cycle push strobe into Data_Buffer.
- state_out  out  2  current state encoding.
- stall_cnt  out  16  number of ticks withheld due to backpressure.

## Operation
- States:
  - HALT=0 (reset state)
  - RUN=1
  - STEP=2
  - STALL=3
- Request priority is halt_req > step_req > run_req. The next state is resolved from requests first; the tick action then uses that resolved state.
- HALT:
  - halt_req keeps the block in HALT.
  - step_req moves to STEP.
  - run_req moves to RUN.
  - Otherwise the block stays in HALT.
- RUN:
  - halt_req moves to HALT.
  - step_req is ignored.
  - On a tick with buffer_occ >= FULL_THRESH: no core_en, move to STALL, stall_cnt +1.
  - On a tick with buffer_occ < FULL_THRESH: issue core_en.
- STEP:
  - halt_req moves to HALT with no step issued.
  - On the first tick with buffer_occ < FULL_THRESH: issue core_en, then move to HALT.
  - On a tick with buffer_occ >= FULL_THRESH: stay in STEP, stall_cnt +1.
- STALL:
  - halt_req moves to HALT.
  - On a tick with buffer_occ < FULL_THRESH: issue core_en, move to RUN.
  - Otherwise stall_cnt +1 per tick.
- stall_cnt saturates at 16'hFFFF and is cleared only by reset.
- buf_push is asserted for one cycle, on the cycle after core_en, when wb_valid was high during the core_en cycle. If wb_valid was low, no push occurs.

## Timing
- Reset (n_rst low at a clk edge):
  - Divider count, core_en, buf_push and stall_cnt go to 0.
  - state_out goes to 0 (HALT).
- The divider counts 0..DIV_RATIO-1 and is free-running in every state. A tick occurs in the cycle where count == DIV_RATIO-1. The first tick is cycle DIV_RATIO-1 after reset release.
- core_en is high in the cycle after the tick cycle, for exactly one cycle. Spacing between consecutive core_en pulses is exactly DIV_RATIO cycles.
- buf_push lags core_en by 1 cycle. Total latency from tick to buf_push is 2 cycles.
- A request in a tick cycle takes effect in that tick:
  - halt_req in RUN suppresses that step.
  - run_req in HALT issues that step.
- A reset asserted between core_en and buf_push drops the pending push.
- Occupancy is sampled only in tick cycles. buffer_occ == FULL_THRESH-1 permits a step.

## Configuration
- `CORE_RUN_CTRL_STALL_CNT_EN`:
  - Defined: the stall_cnt register and its increment logic are present.
  - Undefined: stall_cnt is tied to 16'h0000, no register is inferred, and state and handshake behaviour are unchanged.

## Structure
- Package `core_ctrl_pkg` holds:
  - the state typedef and 2-bit encodings HALT/RUN/STEP/STALL;
  - the STALL_CNT_MAX constant.
- One sub-module, `core_tick_gen`: parameterised modulo-DIV_RATIO counter with a registered tick output. The FSM and the push pipeline live in the top of core_run_ctrl.

## Test plan
- Reset, then idle 40 cycles with no requests -> core_en never asserts, state_out=0, stall_cnt=0.
- run_req pulse, buffer_occ=0, DIV_RATIO=9 -> core_en pulses exactly 9 cycles apart; wb_valid=1 gives buf_push one cycle after each core_en.
- In RUN, buffer_occ=30 for 3 ticks, then 29 -> state_out=3, no core_en for 3 ticks, stall_cnt=3; at the next tick core_en=1 and state_out=1.
- step_req from HALT -> exactly one core_en at the next tick, then state_out=0; a second step_req gives one more core_en.
- halt_req and step_req together in a tick cycle while in RUN -> no core_en, state_out=0.
- Reset asserted in the cycle after core_en with wb_valid=1 -> buf_push stays 0 and all outputs return to reset values; with the macro undefined, stall_cnt=0 after 5 stalled ticks.
